// File: rtl/rnn_pkg.sv
// Shared constants and types for the RNN memory/host responder.
package rnn_pkg;

   localparam int unsigned DATA_W = 20;
   localparam int unsigned ADDR_W = 17;
   localparam int unsigned X_W    = 32;

   // Bank select encodings on msel / ld_sel
   localparam logic [2:0] MSEL_WIH = 3'b000;
   localparam logic [2:0] MSEL_BIH = 3'b001;
   localparam logic [2:0] MSEL_WHH = 3'b010;
   localparam logic [2:0] MSEL_BHH = 3'b011;
   localparam logic [2:0] MSEL_T   = 3'b100;
   localparam logic [2:0] MSEL_OUT = 3'b101;
   localparam logic [2:0] MSEL_RSV = 3'b110;

   localparam int unsigned WIH_DEPTH  = 2048;
   localparam int unsigned WHH_DEPTH  = 4096;
   localparam int unsigned BIAS_DEPTH = 64;

   // Start/ready/busy/done handshake states
   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StRun
   } hs_state_e;

endpackage

// File: rtl/rnn_xfifo.sv
// Input-vector FIFO. Push while full is accepted only when a pop frees a slot
// in the same cycle; a push into an empty FIFO cannot be popped that cycle.
module rnn_xfifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned W     = 32
) (
   input  logic         i_clk,
   input  logic         i_reset_n,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_head,
   output logic         o_full,
   output logic         o_empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = 1;
   localparam logic [PTR_W:0]   CNT_ONE = 1;

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_do_pop;
   logic             w_do_push;

   assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // Storage write; contents are not cleared by reset
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_ONE;
         else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_ONE;
      end
   end

endmodule

// File: rtl/rnn_mem_responder.sv
// Memory/host-side responder for the RNN engine: banked weight/bias/T/output
// storage with 1-cycle reads, h_t write-back capture, x-vector FIFO and the
// start/ready/busy/done handshake.
module rnn_mem_responder
   import rnn_pkg::*;
#(
   parameter int unsigned X_DEPTH = 16,
   parameter int unsigned OUT_T   = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   output logic              o_ready,
   input  logic              i_busy,
   input  logic              i_en,
   output logic [X_W-1:0]    o_idata,
   input  logic              i_mce,
   input  logic [2:0]        i_msel,
   input  logic [ADDR_W-1:0] i_maddr,
   input  logic [DATA_W-1:0] i_mdata_w,
   output logic [DATA_W-1:0] o_mdata_r,
   input  logic              i_ld_en,
   input  logic [2:0]        i_ld_sel,
   input  logic [ADDR_W-1:0] i_ld_addr,
   input  logic [DATA_W-1:0] i_ld_data,
   input  logic              i_x_push,
   input  logic [X_W-1:0]    i_x_data,
   output logic              o_x_full,
   input  logic              i_start,
   output logic              o_done,
   output logic [2:0]        o_err
);

   localparam int unsigned OUT_DEPTH = OUT_T * 64;
   localparam int unsigned OUT_AW    = $clog2(OUT_DEPTH);

   logic [DATA_W-1:0] r_wih [WIH_DEPTH];
   logic [DATA_W-1:0] r_bih [BIAS_DEPTH];
   logic [DATA_W-1:0] r_whh [WHH_DEPTH];
   logic [DATA_W-1:0] r_bhh [BIAS_DEPTH];
   logic [DATA_W-1:0] r_out [OUT_DEPTH];
   logic [DATA_W-1:0] r_t;
   logic [DATA_W-1:0] r_mdata_r;
   logic [X_W-1:0]    r_idata;
   logic [2:0]        r_err;
   logic              r_ready;
   logic              r_done;
   hs_state_e         r_state;

   logic              w_eng_wr;
   logic              w_eng_in_range;
   logic [OUT_AW-1:0] w_eng_oidx;
   logic              w_ld_ok;
   logic              w_ld_in_range;
   logic [OUT_AW-1:0] w_ld_oidx;
   logic [DATA_W-1:0] w_rd_data;
   logic [X_W-1:0]    w_x_head;
   logic              w_x_empty;

   // Output-bank address is {t, h}, so the low bits index the bank directly once t < OUT_T
   assign w_eng_wr       = i_mce && (i_msel == MSEL_OUT);
   assign w_eng_in_range = 32'(i_maddr[16:6]) < OUT_T;
   assign w_eng_oidx     = i_maddr[OUT_AW-1:0];
   assign w_ld_in_range  = 32'(i_ld_addr[16:6]) < OUT_T;
   assign w_ld_oidx      = i_ld_addr[OUT_AW-1:0];
   // Engine access to the same bank takes the port; preload only while the engine is idle
   assign w_ld_ok = i_ld_en && !i_busy && !(i_mce && (i_msel == i_ld_sel));

   rnn_xfifo #(
      .DEPTH (X_DEPTH),
      .W     (X_W)
   ) u_xfifo (
      .i_clk     (i_clk),
      .i_reset_n (i_reset),
      .i_push    (i_x_push),
      .i_data    (i_x_data),
      .i_pop     (i_en),
      .o_head    (w_x_head),
      .o_full    (o_x_full),
      .o_empty   (w_x_empty)
   );

   // Read mux over all banks; output-bank reads return the pre-write value
   always_comb begin
      w_rd_data = '0;
      case (i_msel)
         MSEL_WIH: w_rd_data = r_wih[i_maddr[10:0]];
         MSEL_BIH: w_rd_data = r_bih[i_maddr[5:0]];
         MSEL_WHH: w_rd_data = r_whh[i_maddr[11:0]];
         MSEL_BHH: w_rd_data = r_bhh[i_maddr[5:0]];
         MSEL_T:   w_rd_data = r_t;
         MSEL_OUT: w_rd_data = w_eng_in_range ? r_out[w_eng_oidx] : '0;
         default:  w_rd_data = '0;
      endcase
   end

   // Bank array writes: engine write-back and host preload (not cleared by reset)
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         if (w_eng_wr && w_eng_in_range) r_out[w_eng_oidx] <= i_mdata_w;
         if (w_ld_ok) begin
            case (i_ld_sel)
               MSEL_WIH: r_wih[i_ld_addr[10:0]] <= i_ld_data;
               MSEL_BIH: r_bih[i_ld_addr[5:0]]  <= i_ld_data;
               MSEL_WHH: r_whh[i_ld_addr[11:0]] <= i_ld_data;
               MSEL_BHH: r_bhh[i_ld_addr[5:0]]  <= i_ld_data;
               MSEL_OUT: if (w_ld_in_range) r_out[w_ld_oidx] <= i_ld_data;
               default: ;
            endcase
         end
      end
   end

   // Registered read data, T register, x-vector output and sticky errors
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_mdata_r <= '0;
         r_t       <= '0;
         r_idata   <= '0;
         r_err     <= '0;
      end else begin
         if (i_mce) r_mdata_r <= w_rd_data;
         if (w_ld_ok && (i_ld_sel == MSEL_T)) r_t <= i_ld_data;
         if (i_en) r_idata <= w_x_empty ? '0 : w_x_head;
         if (i_ld_en && i_busy)             r_err[2] <= 1'b1;
         if (w_eng_wr && !w_eng_in_range)   r_err[1] <= 1'b1;
         if (i_en && w_x_empty)             r_err[0] <= 1'b1;
      end
   end

   // Handshake FSM: IDLE -> REQ (ready) -> RUN (busy seen) -> IDLE with done pulse
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state <= StIdle;
         r_ready <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            StIdle: begin
               if (i_start && !i_busy) begin
                  r_state <= StReq;
                  r_ready <= 1'b1;
               end
            end
            StReq: begin
               if (i_busy) begin
                  r_state <= StRun;
                  r_ready <= 1'b0;
               end
            end
            StRun: begin
               if (!i_busy) begin
                  r_state <= StIdle;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= StIdle;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   assign o_mdata_r = r_mdata_r;
   assign o_idata   = r_idata;
   assign o_err     = r_err;
   assign o_ready   = r_ready;
   assign o_done    = r_done;

endmodule

// File: tb/tb_rnn_mem_responder.sv
// Self-checking bench for rnn_mem_responder: table-driven bank accesses with a
// read-data scoreboard, FIFO model queue, handshake and reset sequences.
module tb_rnn_mem_responder;

   localparam int unsigned X_DEPTH = 16;
   localparam int unsigned OUT_T   = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        ready;
   logic        busy;
   logic        i_en;
   logic [31:0] idata;
   logic        mce;
   logic [2:0]  msel;
   logic [16:0] maddr;
   logic [19:0] mdata_w;
   logic [19:0] mdata_r;
   logic        ld_en;
   logic [2:0]  ld_sel;
   logic [16:0] ld_addr;
   logic [19:0] ld_data;
   logic        x_push;
   logic [31:0] x_data;
   logic        x_full;
   logic        start;
   logic        done;
   logic [2:0]  err;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [2:0]  sel;
      logic [16:0] addr;
      logic [19:0] data;
   } ld_vec_t;

   typedef struct packed {
      logic [2:0]  sel;
      logic [16:0] addr;
      logic [19:0] wdata;
      logic [19:0] exp;
   } rd_vec_t;

   localparam int NLD = 9;
   localparam int NRD = 15;
   ld_vec_t     ld_tab [NLD];
   rd_vec_t     rd_tab [NRD];
   logic [19:0] rd_q [$];
   logic [31:0] x_q  [$];
   logic [31:0] x_exp;

   rnn_mem_responder #(
      .X_DEPTH (X_DEPTH),
      .OUT_T   (OUT_T)
   ) dut (
      .i_clk     (clk),
      .i_reset   (reset),
      .o_ready   (ready),
      .i_busy    (busy),
      .i_en      (i_en),
      .o_idata   (idata),
      .i_mce     (mce),
      .i_msel    (msel),
      .i_maddr   (maddr),
      .i_mdata_w (mdata_w),
      .o_mdata_r (mdata_r),
      .i_ld_en   (ld_en),
      .i_ld_sel  (ld_sel),
      .i_ld_addr (ld_addr),
      .i_ld_data (ld_data),
      .i_x_push  (x_push),
      .i_x_data  (x_data),
      .o_x_full  (x_full),
      .i_start   (start),
      .o_done    (done),
      .o_err     (err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Advance one clock; outputs are observed 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_x(input logic [31:0] v);
      x_push = 1'b1;
      x_data = v;
      x_q.push_back(v);
      step();
      x_push = 1'b0;
   endtask

   // Pop request; the expected value comes from the model queue (0 on underrun)
   task automatic pop_x(input string name);
      i_en  = 1'b1;
      x_exp = (x_q.size() > 0) ? x_q.pop_front() : 32'h0;
      step();
      i_en = 1'b0;
      check(name, idata, x_exp);
   endtask

   initial begin
      ld_tab[0] = '{3'b000, 17'd5,               20'h0ABCD};
      ld_tab[1] = '{3'b001, 17'd3,               20'h11111};
      ld_tab[2] = '{3'b010, 17'd4095,            20'h2FEDC};
      ld_tab[3] = '{3'b011, 17'd63,              20'h33333};
      ld_tab[4] = '{3'b100, 17'd0,               20'h00042};
      ld_tab[5] = '{3'b101, {11'd2, 6'd3},       20'h55555};
      ld_tab[6] = '{3'b101, {11'd15, 6'd63},     20'h0F0F0};
      ld_tab[7] = '{3'b101, {11'd0, 6'd3},       20'h01234};
      ld_tab[8] = '{3'b110, 17'd5,               20'h77777};

      rd_tab[0]  = '{3'b000, 17'd5,           20'h0,     20'h0ABCD};
      rd_tab[1]  = '{3'b000, 17'h10005,       20'h0,     20'h0ABCD};
      rd_tab[2]  = '{3'b001, 17'd3,           20'h0,     20'h11111};
      rd_tab[3]  = '{3'b001, 17'h00043,       20'h0,     20'h11111};
      rd_tab[4]  = '{3'b010, 17'd4095,        20'h0,     20'h2FEDC};
      rd_tab[5]  = '{3'b011, 17'd63,          20'h0,     20'h33333};
      rd_tab[6]  = '{3'b100, 17'h1ABCD,       20'h0,     20'h00042};
      rd_tab[7]  = '{3'b110, 17'd5,           20'h0,     20'h00000};
      rd_tab[8]  = '{3'b101, {11'd2, 6'd3},   20'h10000, 20'h55555};
      rd_tab[9]  = '{3'b101, {11'd2, 6'd3},   20'h0AAAA, 20'h10000};
      rd_tab[10] = '{3'b101, {11'd16, 6'd3},  20'h12345, 20'h00000};
      rd_tab[11] = '{3'b101, {11'd15, 6'd63}, 20'h0BEEF, 20'h0F0F0};
      rd_tab[12] = '{3'b101, {11'd2, 6'd3},   20'h00000, 20'h0AAAA};
      rd_tab[13] = '{3'b101, {11'd0, 6'd3},   20'h00000, 20'h01234};
      rd_tab[14] = '{3'b000, 17'd5,           20'h0,     20'h0ABCD};

      reset = 1'b0; busy = 1'b0; i_en = 1'b0; mce = 1'b0; msel = '0; maddr = '0;
      mdata_w = '0; ld_en = 1'b0; ld_sel = '0; ld_addr = '0; ld_data = '0;
      x_push = 1'b0; x_data = '0; start = 1'b0;
      step();
      step();
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_idata", idata, 32'd0);
      check("rst_mdata_r", {12'd0, mdata_r}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {29'd0, err}, 32'd0);
      check("rst_x_full", {31'd0, x_full}, 32'd0);
      reset = 1'b1;
      step();

      // Preload banks while the engine is idle
      for (int i = 0; i < NLD; i++) begin
         ld_en = 1'b1; ld_sel = ld_tab[i].sel; ld_addr = ld_tab[i].addr; ld_data = ld_tab[i].data;
         step();
      end
      ld_en = 1'b0;

      // Engine read/write vectors; expected data is scoreboarded one cycle ahead
      for (int i = 0; i < NRD; i++) begin
         mce = 1'b1; msel = rd_tab[i].sel; maddr = rd_tab[i].addr; mdata_w = rd_tab[i].wdata;
         rd_q.push_back(rd_tab[i].exp);
         step();
         mce = 1'b0;
         check($sformatf("bank_vec%0d", i), {12'd0, mdata_r}, {12'd0, rd_q.pop_front()});
      end
      msel = 3'b001; maddr = 17'd3;
      step();
      check("mce0_hold", {12'd0, mdata_r}, 32'h0ABCD);
      check("err_ovf", {29'd0, err}, 32'd2);

      // FIFO: three vectors then an underrun
      push_x(32'hA000_000A);
      push_x(32'hB000_000B);
      push_x(32'hC000_000C);
      for (int i = 0; i < 4; i++) pop_x($sformatf("fifo_pop%0d", i));
      check("err_underrun", {29'd0, err}, 32'd3);

      // Push into empty FIFO is not poppable in the same cycle
      x_push = 1'b1; x_data = 32'hD000_000D; i_en = 1'b1;
      step();
      x_push = 1'b0; i_en = 1'b0;
      check("push_empty_pop", idata, 32'd0);
      x_q.push_back(32'hD000_000D);
      pop_x("pop_after_empty_push");

      // Fill to depth, drop an overflow push, then push+pop while full
      for (int i = 0; i < X_DEPTH; i++) begin
         push_x(32'h1000_0000 + i);
         check($sformatf("fill_full%0d", i), {31'd0, x_full}, {31'd0, (i == X_DEPTH - 1)});
      end
      x_push = 1'b1; x_data = 32'hDEAD_BEEF;
      step();
      x_push = 1'b0;
      check("full_drop_full", {31'd0, x_full}, 32'd1);
      x_push = 1'b1; x_data = 32'h2000_0000; i_en = 1'b1;
      x_exp = x_q.pop_front();
      x_q.push_back(32'h2000_0000);
      step();
      x_push = 1'b0; i_en = 1'b0;
      check("full_pushpop_data", idata, x_exp);
      check("full_pushpop_full", {31'd0, x_full}, 32'd1);
      for (int i = 0; i < X_DEPTH; i++) pop_x($sformatf("drain%0d", i));
      check("drained_not_full", {31'd0, x_full}, 32'd0);
      check("err_no_ld", {29'd0, err}, 32'd3);

      // Handshake and preload-while-busy
      start = 1'b1;
      step();
      start = 1'b0;
      check("hs_ready", {31'd0, ready}, 32'd1);
      step();
      check("hs_ready_hold", {31'd0, ready}, 32'd1);
      busy = 1'b1;
      step();
      check("hs_ready_clr", {31'd0, ready}, 32'd0);
      check("hs_no_done", {31'd0, done}, 32'd0);
      ld_en = 1'b1; ld_sel = 3'b000; ld_addr = 17'd5; ld_data = 20'hFFFFF; start = 1'b1;
      step();
      ld_en = 1'b0; start = 1'b0;
      check("ld_err", {29'd0, err}, 32'd7);
      check("start_busy_ign", {31'd0, ready}, 32'd0);
      busy = 1'b0;
      step();
      check("done_pulse", {31'd0, done}, 32'd1);
      step();
      check("done_clear", {31'd0, done}, 32'd0);
      check("ready_idle", {31'd0, ready}, 32'd0);
      mce = 1'b1; msel = 3'b000; maddr = 17'd5;
      step();
      mce = 1'b0;
      check("ld_busy_unchanged", {12'd0, mdata_r}, 32'h0ABCD);

      // Reset during a run with a read in flight
      start = 1'b1;
      step();
      start = 1'b0;
      check("rr_ready", {31'd0, ready}, 32'd1);
      push_x(32'hE000_000E);
      busy = 1'b1;
      mce = 1'b1; msel = 3'b011; maddr = 17'd63; reset = 1'b0;
      step();
      mce = 1'b0;
      x_q.delete();
      check("rr_mdata_r", {12'd0, mdata_r}, 32'd0);
      check("rr_ready0", {31'd0, ready}, 32'd0);
      check("rr_err0", {29'd0, err}, 32'd0);
      check("rr_done0", {31'd0, done}, 32'd0);
      reset = 1'b1;
      pop_x("rr_fifo_empty");
      check("rr_underrun", {29'd0, err}, 32'd1);
      busy = 1'b0;
      step();
      check("rr_no_done", {31'd0, done}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
